// File: rtl/axis_bram_pkg.sv
// Shared constants and state encoding for the axis_bram write path.
package axis_bram_pkg;

  localparam int DATA_W         = 32;
  localparam int STRB_W         = DATA_W / 8;
  localparam int WORDS_PER_LINE = 36;
  localparam int LINE_CNT_W     = 12;
  localparam int WORD_CNT_W     = $clog2(WORDS_PER_LINE);

  localparam logic [DATA_W-1:0] PAD_WORD = '0;

  // Framer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // A zero line count would make an empty frame; treat it as one line.
  function automatic logic [LINE_CNT_W-1:0] eff_lines(input logic [LINE_CNT_W-1:0] cfg);
    return (cfg == '0) ? LINE_CNT_W'(1) : cfg;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer used as the registered output stage.
// s_ready comes straight from a flop so upstream never sees m_ready combinationally.
module axis_skid_buf #(
  parameter int W = 37
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic         out_valid_reg, out_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic         ready_reg, ready_next;
  logic [W-1:0] out_data_reg, out_data_next;
  logic [W-1:0] skid_data_reg, skid_data_next;

  // Drain the output slot first, then place any accepted word in the first free slot.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (m_ready || !out_valid_reg) begin
      out_valid_next  = skid_valid_reg;
      if (skid_valid_reg) out_data_next = skid_data_reg;
      skid_valid_next = 1'b0;
    end
    if (s_valid && ready_reg) begin
      if (!out_valid_next) begin
        out_valid_next = 1'b1;
        out_data_next  = s_data;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = s_data;
      end
    end
    ready_next = !skid_valid_next;
  end

  // Storage registers; ready stays low during reset and rises on the first edge after.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= ready_next;
    end
  end

  assign s_ready = ready_reg;
  assign m_data  = out_data_reg;
  assign m_valid = out_valid_reg;

endmodule

// File: rtl/axis_line_framer.sv
// Re-frames an arbitrary-length AXI-Stream packet into whole BRAM lines and frames:
// short packets are padded to the line boundary, overlong packets are truncated.
module axis_line_framer
  import axis_bram_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [LINE_CNT_W-1:0] cfg_lines,
  input  logic [DATA_W-1:0]     s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  output logic                  s00_axis_tready,
  input  logic                  s00_axis_tlast,
  output logic [DATA_W-1:0]     m00_axis_tdata,
  output logic [STRB_W-1:0]     m00_axis_tstrb,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
  output logic                  frame_done,
  output logic                  trunc_err,
  output logic                  busy
);

  localparam int PAYLOAD_W = DATA_W + STRB_W + 1;

  logic [1:0]            state_reg, state_next;
  logic [WORD_CNT_W-1:0] word_cnt_reg, word_cnt_next;
  logic [LINE_CNT_W-1:0] line_cnt_reg, line_cnt_next;
  logic [LINE_CNT_W-1:0] lines_reg, lines_next, cur_lines;
  logic                  trunc_reg, trunc_next;
  logic [1:0]            open_frames_reg;
  logic                  frame_done_reg;

  logic                  buf_ready, buf_valid, buf_last;
  logic [DATA_W-1:0]     buf_data;
  logic [STRB_W-1:0]     buf_strb;
  logic [PAYLOAD_W-1:0]  buf_out;

  logic in_fire, pad_fire, last_word, last_line, frame_open, frame_close;

  // PAD owns the output path; DROP swallows words without touching it.
  assign s00_axis_tready = (state_reg == ST_DROP) || ((state_reg != ST_PAD) && buf_ready);
  assign in_fire   = s00_axis_tvalid && s00_axis_tready;
  assign pad_fire  = (state_reg == ST_PAD) && buf_ready;
  // In IDLE the line count is not latched yet, so decisions use the live config.
  assign cur_lines = (state_reg == ST_IDLE) ? eff_lines(cfg_lines) : lines_reg;
  assign last_word = (word_cnt_reg == WORD_CNT_W'(WORDS_PER_LINE - 1));
  assign last_line = (line_cnt_reg == cur_lines - LINE_CNT_W'(1));

  // Framing decisions per accepted input word or emitted pad word.
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    line_cnt_next = line_cnt_reg;
    lines_next    = lines_reg;
    trunc_next    = trunc_reg;
    buf_valid     = 1'b0;
    buf_data      = s00_axis_tdata;
    buf_strb      = '1;
    buf_last      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_PASS: begin
        buf_valid = s00_axis_tvalid;
        if (in_fire) begin
          lines_next    = cur_lines;
          state_next    = ST_PASS;
          word_cnt_next = word_cnt_reg + WORD_CNT_W'(1);
          if (last_word) begin
            word_cnt_next = '0;
            line_cnt_next = line_cnt_reg + LINE_CNT_W'(1);
            if (s00_axis_tlast || last_line) begin
              // Frame ends here: clean end, short frame, or start of truncation.
              buf_last      = 1'b1;
              line_cnt_next = '0;
              state_next    = s00_axis_tlast ? ST_IDLE : ST_DROP;
              if (!s00_axis_tlast) trunc_next = 1'b1;
            end
          end else if (s00_axis_tlast) begin
            state_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        buf_valid = 1'b1;
        buf_data  = PAD_WORD;
        buf_strb  = '0;
        if (pad_fire) begin
          word_cnt_next = word_cnt_reg + WORD_CNT_W'(1);
          if (last_word) begin
            buf_last      = 1'b1;
            word_cnt_next = '0;
            line_cnt_next = '0;
            state_next    = ST_IDLE;
          end
        end
      end
      default: begin
        if (in_fire && s00_axis_tlast) state_next = ST_IDLE;
      end
    endcase
  end

  // Framer state and counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      line_cnt_reg <= '0;
      lines_reg    <= '0;
      trunc_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      line_cnt_reg <= line_cnt_next;
      lines_reg    <= lines_next;
      trunc_reg    <= trunc_next;
    end
  end

  // A new frame may start while the previous tlast still waits downstream,
  // so busy tracks frames opened but not yet closed at the output.
  assign frame_open  = (state_reg == ST_IDLE) && in_fire;
  assign frame_close = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

  // Frame completion pulse and open-frame count.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      open_frames_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= frame_close;
      case ({frame_open, frame_close})
        2'b10:   open_frames_reg <= open_frames_reg + 2'd1;
        2'b01:   open_frames_reg <= open_frames_reg - 2'd1;
        default: open_frames_reg <= open_frames_reg;
      endcase
    end
  end

  axis_skid_buf #(
    .W(PAYLOAD_W)
  ) u_out_buf (
    .aclk    (aclk),
    .areset  (areset),
    .s_data  ({buf_last, buf_strb, buf_data}),
    .s_valid (buf_valid),
    .s_ready (buf_ready),
    .m_data  (buf_out),
    .m_valid (m00_axis_tvalid),
    .m_ready (m00_axis_tready)
  );

  assign m00_axis_tdata = buf_out[DATA_W-1:0];
  assign m00_axis_tstrb = buf_out[DATA_W +: STRB_W];
  assign m00_axis_tlast = buf_out[PAYLOAD_W-1];
  assign frame_done     = frame_done_reg;
  assign trunc_err      = trunc_reg;
  assign busy           = (open_frames_reg != 2'd0);

endmodule

// File: tb/tb_axis_line_framer.sv
// Directed bench for axis_line_framer with a packet-level output model and scoreboard.
`timescale 1ns/1ps
module tb_axis_line_framer;
  import axis_bram_pkg::*;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic [LINE_CNT_W-1:0] cfg_lines = '0;
  logic [DATA_W-1:0]     s_tdata = '0;
  logic                  s_tvalid = 1'b0;
  logic                  s_tready;
  logic                  s_tlast = 1'b0;
  logic [DATA_W-1:0]     m_tdata;
  logic [STRB_W-1:0]     m_tstrb;
  logic                  m_tvalid;
  logic                  m_tready = 1'b1;
  logic                  m_tlast;
  logic                  frame_done, trunc_err, busy;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  int    checks = 0;
  int    errors = 0;
  logic  exp_trunc = 1'b0;
  int    ready_mode = 0;
  int    out_count = 0;
  int    fd_count = 0;
  logic  fd_pending = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_b;

  always #5 aclk = ~aclk;

  axis_line_framer dut (
    .aclk            (aclk),
    .areset          (areset),
    .cfg_lines       (cfg_lines),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast),
    .frame_done      (frame_done),
    .trunc_err       (trunc_err),
    .busy            (busy)
  );

  // Packet-level model: a frame holds max(cfg,1)*36 words; anything beyond is
  // dropped, and a short packet is zero-padded to the next 36-word boundary.
  task automatic model_packet(input int n, input int cfg, input int base);
    int cap, emit, total;
    beat_t b;
    cap   = ((cfg == 0) ? 1 : cfg) * WORDS_PER_LINE;
    emit  = (n > cap) ? cap : n;
    total = ((emit + WORDS_PER_LINE - 1) / WORDS_PER_LINE) * WORDS_PER_LINE;
    for (int i = 0; i < total; i++) begin
      b.data = (i < emit) ? DATA_W'(base + i) : PAD_WORD;
      b.strb = (i < emit) ? 4'hF : 4'h0;
      b.last = (i == total - 1);
      exp_q.push_back(b);
    end
    if (n > cap) exp_trunc = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Sends words 0..stop_after-1 of an n-word packet; cfg_lines is disturbed
  // after the first word to show the latched value is what counts.
  task automatic send_packet(input int n, input int cfg, input int base, input int stop_after);
    int waited;
    logic ok;
    cfg_lines = cfg[LINE_CNT_W-1:0];
    for (int i = 0; i < stop_after; i++) begin
      s_tdata  = DATA_W'(base + i);
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      waited   = 0;
      ok       = 1'b0;
      while (!ok && waited < 2000) begin
        @(negedge aclk);
        ok = s_tready;
        @(posedge aclk);
        #1;
        waited++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL send_timeout word=%0d tready=%0b required=1", i, s_tready);
        break;
      end
      $display("sent word %0d data=%0h last=%0b", i, base + i, (i == n - 1));
      if (i == 0) cfg_lines = LINE_CNT_W'(1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge aclk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // Downstream ready: always high or a coin flip each cycle.
  always @(posedge aclk) begin
    #1;
    m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Scoreboard: outputs are stable at the falling edge and any valid&ready seen
  // here transfers on the next rising edge.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
      fd_pending = 1'b0;
    end else begin
      checks++;
      if (frame_done !== fd_pending) begin
        errors++;
        $display("FAIL frame_done got=%0b required=%0b", frame_done, fd_pending);
      end
      if (frame_done) fd_count++;
      fd_pending = 1'b0;
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || {m_tdata, m_tstrb, m_tlast} !== prev_b) begin
          errors++;
          $display("FAIL stall_hold got=%0b/%0h/%0h/%0b required=1/%0h/%0h/%0b",
                   m_tvalid, m_tdata, m_tstrb, m_tlast, prev_b.data, prev_b.strb, prev_b.last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=%0h/%0h/%0b required=none", m_tdata, m_tstrb, m_tlast);
        end else begin
          exp_b = exp_q.pop_front();
          if ({m_tdata, m_tstrb, m_tlast} !== exp_b) begin
            errors++;
            $display("FAIL out_beat %0d got=%0h/%0h/%0b required=%0h/%0h/%0b", out_count,
                     m_tdata, m_tstrb, m_tlast, exp_b.data, exp_b.strb, exp_b.last);
          end else begin
            $display("out beat %0d data=%0h strb=%0h last=%0b", out_count, m_tdata, m_tstrb, m_tlast);
          end
          if (exp_b.last) fd_pending = 1'b1;
        end
        out_count++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_b     = {m_tdata, m_tstrb, m_tlast};
    end
  end

  task automatic run_packet(input string name, input int n, input int cfg, input int base,
                            input int exp_out, input logic exp_te);
    out_count = 0;
    fd_count  = 0;
    model_packet(n, cfg, base);
    send_packet(n, cfg, base, n);
    drain();
    check({name, "_out_count"}, 64'(out_count), 64'(exp_out));
    check({name, "_frame_done_count"}, 64'(fd_count), 64'd1);
    check({name, "_busy_idle"}, 64'(busy), 64'd0);
    check({name, "_trunc_err"}, 64'(trunc_err), 64'(exp_te));
    check({name, "_model_trunc"}, 64'(exp_trunc), 64'(exp_te));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tstrb", 64'(m_tstrb), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_misc", 64'({frame_done, trunc_err, busy}), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("post_rst_tready", 64'(s_tready), 64'd1);

    // Two-line frame, exact length
    run_packet("s1_72w", 72, 2, 0, 72, 1'b0);
    // Short packet padded to the line
    run_packet("s2_3w", 3, 1, 100, 36, 1'b0);
    // Single word: one data word plus 35 pads
    run_packet("s2b_1w", 1, 1, 150, 36, 1'b0);
    // Short frame ending exactly on a line boundary
    run_packet("s2c_36w_cfg2", 36, 2, 180, 36, 1'b0);
    // Overlong packet truncated, then a fresh frame
    run_packet("s3_40w", 40, 1, 200, 36, 1'b1);
    run_packet("s3_next", 3, 1, 300, 36, 1'b1);
    // Random downstream stalls
    ready_mode = 1;
    run_packet("s4_rand", 72, 2, 400, 72, 1'b1);
    ready_mode = 0;
    // Zero line count behaves as one line
    run_packet("s5_cfg0", 36, 0, 500, 36, 1'b1);

    // Reset in the middle of a frame
    out_count = 0;
    fd_count  = 0;
    model_packet(72, 2, 600);
    send_packet(72, 2, 600, 20);
    check("s6_busy_mid", 64'(busy), 64'd1);
    areset = 1'b1;
    #1;
    check("s6_rst_tready", 64'(s_tready), 64'd0);
    check("s6_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("s6_rst_data", 64'({m_tdata, m_tstrb, m_tlast}), 64'd0);
    check("s6_rst_misc", 64'({frame_done, trunc_err, busy}), 64'd0);
    exp_q.delete();
    exp_trunc = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("s6_aborted_frame_done", 64'(fd_count), 64'd0);
    run_packet("s6_after", 3, 1, 700, 36, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
